ps2_scancode_decoder: RTL and testbench

Downstream stage of the PS/2 receive path. Consumes each 9-bit frame (`CODE`, `DONE`) from the PS/2 deserializer. Checks odd parity, then folds the `E0` (extended) and `F0` (break) prefix bytes into single key events. Completed events are buffered in a small FIFO for the keyboard-command logic to pop.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_event_fifo.sv | 58 +++++
 rtl/ps2_scancode_decoder.sv | 103 ++++++++++
 tb/tb_ps2_scancode_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decode path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int unsigned PS2_EVENT_W = 10;

  // Encoding {ext, brk} lets a prefix byte simply OR its bit into the state.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PRE_F0   = 2'b01,
    PRE_E0   = 2'b10,
    PRE_E0F0 = 2'b11
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  function automatic ps2_state_t ps2_next_state(input ps2_state_t cur, input logic [7:0] data);
    if (data == PS2_EXT_PREFIX) begin
      return ps2_state_t'(cur | PRE_E0);
    end else if (data == PS2_BRK_PREFIX) begin
      return ps2_state_t'(cur | PRE_F0);
    end
    return IDLE;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO holding decoded key events.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_rd_c;
  logic             do_wr_c;

  // A pop frees the slot the simultaneous write needs when full.
  assign do_rd_c = rd_en & ~empty;
  assign do_wr_c = wr_en & (~full | do_rd_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_rd_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Parity-checks PS/2 frames, folds E0/F0 prefixes into key events and queues them.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       DONE,
  input  logic [8:0] CODE,
  input  logic       KEY_RD,
  output logic       EMPTY,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_BREAK,
  output logic       PARITY_ERR,
  output logic       OVERFLOW
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  ps2_state_t       state;
  logic [TW-1:0]    tmo_cnt;
  logic             prev_done;
  logic             parity_err;
  logic             overflow;

  logic             accept_c;
  logic             parity_ok_c;
  logic             is_prefix_c;
  logic             push_c;
  logic             pop_c;
  logic             expire_c;
  ps2_event_t       event_c;
  ps2_event_t       head;
  logic             fifo_full;
  logic             fifo_empty;

  assign accept_c    = DONE & ~prev_done;
  assign parity_ok_c = ^CODE;
  assign is_prefix_c = (CODE[7:0] == PS2_EXT_PREFIX) || (CODE[7:0] == PS2_BRK_PREFIX);
  assign pop_c       = KEY_RD & ~fifo_empty;
  assign expire_c    = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Event emitted for a valid non-prefix byte, tagged by the pending prefix.
  always_comb begin
    push_c  = 1'b0;
    event_c = '0;
    if (accept_c && parity_ok_c && !is_prefix_c) begin
      push_c        = 1'b1;
      event_c.ext   = state[1];
      event_c.brk   = state[0];
      event_c.code  = CODE[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      prev_done  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev_done  <= DONE;
      parity_err <= accept_c & ~parity_ok_c;
      overflow   <= push_c & fifo_full & ~pop_c;
      // An accept on the expiry cycle takes priority over the timeout.
      if (accept_c) begin
        tmo_cnt <= '0;
        state   <= parity_ok_c ? ps2_next_state(state, CODE[7:0]) : IDLE;
      end else if (expire_c) begin
        tmo_cnt <= '0;
        state   <= IDLE;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .wr_en   (push_c),
    .wr_data (event_c),
    .rd_en   (pop_c),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign EMPTY      = fifo_empty;
  assign KEY_CODE   = head.code;
  assign KEY_EXT    = head.ext;
  assign KEY_BREAK  = head.brk;
  assign PARITY_ERR = parity_err;
  assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [8:0] code;
  logic       key_rd;
  logic       empty;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       parity_err;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic perr_seen;
  logic perr_after;
  logic ovf_seen;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .DONE       (done),
    .CODE       (code),
    .KEY_RD     (key_rd),
    .EMPTY      (empty),
    .KEY_CODE   (key_code),
    .KEY_EXT    (key_ext),
    .KEY_BREAK  (key_break),
    .PARITY_ERR (parity_err),
    .OVERFLOW   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [8:0] frm(input logic [7:0] b);
    return {~^b, b};
  endfunction

  function automatic logic [31:0] head();
    return {22'd0, key_ext, key_break, key_code};
  endfunction

  // Called at a negedge; one-cycle DONE pulse, optional coincident pop.
  task automatic send(input logic [8:0] c, input logic rd = 1'b0);
    code   = c;
    done   = 1'b1;
    key_rd = rd;
    @(negedge clk);
    perr_seen = parity_err;
    ovf_seen  = overflow;
    done   = 1'b0;
    key_rd = 1'b0;
    @(negedge clk);
    perr_after = parity_err;
  endtask

  task automatic pop();
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [5];
    burst[0] = 8'h15; burst[1] = 8'h1D; burst[2] = 8'h24;
    burst[3] = 8'h2D; burst[4] = 8'h2C;

    rst_n  = 1'b0;
    done   = 1'b0;
    code   = '0;
    key_rd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_head", head(), 32'h000);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // DONE held for three cycles yields one event
    code = 9'h01C;
    done = 1'b1;
    check("t1_empty_before", 32'(empty), 32'd1);
    @(negedge clk);
    check("t1_empty_after", 32'(empty), 32'd0);
    check("t1_head", head(), 32'h01C);
    repeat (2) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    pop();
    check("t1_single", 32'(empty), 32'd1);

    // break prefix
    send(9'h1F0);
    check("t2_no_prefix_evt", 32'(empty), 32'd1);
    send(9'h01C);
    check("t2_head", head(), 32'h11C);
    pop();
    check("t2_drained", 32'(empty), 32'd1);

    // extended + break, extended only
    send(9'h0E0); send(9'h1F0); send(9'h075);
    check("t3_ext_brk", head(), 32'h375);
    pop();
    send(9'h0E0); send(9'h075);
    check("t3_ext", head(), 32'h275);
    pop();
    check("t3_drained", 32'(empty), 32'd1);

    // parity error clears the prefix
    send(9'h1F0);
    send(9'h11C);
    check("t4_perr_pulse", 32'(perr_seen), 32'd1);
    check("t4_perr_single", 32'(perr_after), 32'd0);
    check("t4_no_evt", 32'(empty), 32'd1);
    send(9'h01C);
    check("t4_head", head(), 32'h01C);
    pop();

    // overflow on the fifth event, then in-order drain
    for (int i = 0; i < 5; i++) begin
      send(frm(burst[i]));
      check($sformatf("t5_ovf%0d", i), 32'(ovf_seen), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_pop%0d", i), head(), {24'd0, burst[i]});
      pop();
    end
    check("t5_drained", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) send(frm(burst[i]));
    send(frm(8'h2C), 1'b1);
    check("t5_push_pop_full_ovf", 32'(ovf_seen), 32'd0);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t5_rot%0d", i), head(), {24'd0, burst[i]});
      pop();
    end
    check("t5_rot_drained", 32'(empty), 32'd1);

    // prefix abandoned after the timeout
    send(9'h0E0);
    repeat (19) @(negedge clk);
    send(9'h01C);
    check("t6_timeout", head(), 32'h01C);
    pop();

    // accept on the expiry cycle keeps the prefix
    send(9'h0E0);
    repeat (14) @(negedge clk);
    send(9'h01C);
    check("t6_expiry_edge", head(), 32'h21C);
    pop();

    // reset mid-prefix
    send(9'h1F0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(9'h01C);
    check("t6_rst_head", head(), 32'h01C);
    pop();
    check("t6_rst_drained", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
